// File: rtl/spike_gen_refractory_if.sv
// Bundles the strobe/compare inputs and spike/count outputs of the spike generator.
// Latency: n/a (wiring only); no backpressure, outputs are free-running pulses.
interface spike_gen_refractory_if #(
    parameter int N_CH  = 4,
    parameter int U_W   = 4,
    parameter int REF_W = 3,
    parameter int CNT_W = 8
);
    logic                   en;
    logic [N_CH*U_W-1:0]    u;
    logic [U_W-1:0]         theta;
    logic [REF_W-1:0]       ref_period;
    logic                   cnt_clr;
    logic [N_CH-1:0]        spike;
    logic [N_CH-1:0]        refractory;
    logic                   spike_any;
    logic [CNT_W-1:0]       spike_cnt;

    modport master (
        output en, u, theta, ref_period, cnt_clr,
        input  spike, refractory, spike_any, spike_cnt
    );

    modport slave (
        input  en, u, theta, ref_period, cnt_clr,
        output spike, refractory, spike_any, spike_cnt
    );
endinterface

// File: rtl/spike_gen_refractory.sv
// Per-channel threshold spike generator with refractory hold-off and saturating spike count.
// Latency: 1 cycle from en strobe to spike; no backpressure, downstream must accept every pulse.
module spike_gen_refractory #(
    parameter int N_CH  = 4,
    parameter int U_W   = 4,
    parameter int REF_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spike_gen_refractory_if.slave  sif
);
    localparam int POP_W = $clog2(N_CH + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [REF_W-1:0] ref_cnt [N_CH];
    logic [REF_W-1:0] ref_nxt [N_CH];
    logic [N_CH-1:0]  spike_q;
    logic [N_CH-1:0]  spike_nxt;
    logic [N_CH-1:0]  ge;
    logic [N_CH-1:0]  refr;
    logic             spike_any_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;

    // u >= theta taken as the carry out of u - theta in two's complement form.
    for (genvar g = 0; g < N_CH; g++) begin : g_cmp
        logic [U_W:0] diff;
        assign diff  = {1'b0, sif.u[g*U_W +: U_W]} + {1'b0, ~sif.theta} + {{U_W{1'b0}}, 1'b1};
        assign ge[g] = diff[U_W];
    end

    always_comb begin
        spike_nxt = '0;
        pop       = '0;
        for (int i = 0; i < N_CH; i++) begin
            ref_nxt[i] = ref_cnt[i];
            if (sif.en) begin
                if (ref_cnt[i] != '0) begin
                    ref_nxt[i] = ref_cnt[i] - REF_W'(1);
                end else if (ge[i]) begin
                    spike_nxt[i] = 1'b1;
                    ref_nxt[i]   = sif.ref_period;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + POP_W'(spike_nxt[i]);
        end
        sum = SUM_W'(cnt_q) + SUM_W'(pop);
        // Clear wins over same-edge spikes so a readout snapshot starts from zero.
        if (sif.cnt_clr) begin
            cnt_nxt = '0;
        end else if (sum > CNT_MAX) begin
            cnt_nxt = '1;
        end else begin
            cnt_nxt = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                ref_cnt[i] <= '0;
            end
            spike_q     <= '0;
            spike_any_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                ref_cnt[i] <= ref_nxt[i];
            end
            spike_q     <= spike_nxt;
            spike_any_q <= |spike_nxt;
            cnt_q       <= cnt_nxt;
        end
    end

    always_comb begin
        refr = '0;
        for (int i = 0; i < N_CH; i++) begin
            refr[i] = (ref_cnt[i] != '0);
        end
    end

    assign sif.spike      = spike_q;
    assign sif.spike_any  = spike_any_q;
    assign sif.spike_cnt  = cnt_q;
    assign sif.refractory = refr;
endmodule

// File: tb/tb_spike_gen_refractory.sv
// Directed bench for spike_gen_refractory: vector table plus refractory, saturation and reset sequences.
module tb_spike_gen_refractory;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    spike_gen_refractory_if #(.N_CH(4), .U_W(4), .REF_W(3), .CNT_W(8)) sif ();

    spike_gen_refractory #(.N_CH(4), .U_W(4), .REF_W(3), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] u;
        logic [3:0]  theta;
        logic [2:0]  rp;
        logic        clr;
        logic [3:0]  sp;
        logic [3:0]  rf;
        logic        any;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //            en  u         th    rp    clr   spike rf    any   cnt
        vt[0] = '{1'b1, 16'h8888, 4'd8,  3'd0, 1'b0, 4'hF, 4'h0, 1'b1, 8'd4};
        vt[1] = '{1'b1, 16'h8888, 4'd8,  3'd0, 1'b0, 4'hF, 4'h0, 1'b1, 8'd8};
        vt[2] = '{1'b1, 16'h8888, 4'd8,  3'd0, 1'b0, 4'hF, 4'h0, 1'b1, 8'd12};
        vt[3] = '{1'b0, 16'h8888, 4'd8,  3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 8'd12};
        vt[4] = '{1'b1, 16'hFFF7, 4'd8,  3'd0, 1'b0, 4'hE, 4'h0, 1'b1, 8'd15};
        vt[5] = '{1'b1, 16'hFFF8, 4'd8,  3'd0, 1'b0, 4'hF, 4'h0, 1'b1, 8'd19};
        vt[6] = '{1'b1, 16'h0000, 4'd0,  3'd0, 1'b0, 4'hF, 4'h0, 1'b1, 8'd23};
        vt[7] = '{1'b1, 16'hFE0F, 4'd15, 3'd0, 1'b0, 4'h9, 4'h0, 1'b1, 8'd25};
        vt[8] = '{1'b1, 16'hFE0F, 4'd15, 3'd0, 1'b1, 4'h9, 4'h0, 1'b1, 8'd0};
        vt[9] = '{1'b0, 16'hFE0F, 4'd15, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 8'd0};

        rst_n          = 1'b1;
        sif.en         = 1'b0;
        sif.u          = '0;
        sif.theta      = 4'd8;
        sif.ref_period = '0;
        sif.cnt_clr    = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst spike", sif.spike, 4'h0);
        check("rst refr", sif.refractory, 4'h0);
        check("rst any", sif.spike_any, 1'b0);
        check("rst cnt", sif.spike_cnt, 8'd0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            sif.en         = vt[i].en;
            sif.u          = vt[i].u;
            sif.theta      = vt[i].theta;
            sif.ref_period = vt[i].rp;
            sif.cnt_clr    = vt[i].clr;
            tick();
            check($sformatf("vec%0d spike", i), sif.spike, vt[i].sp);
            check($sformatf("vec%0d refr", i), sif.refractory, vt[i].rf);
            check($sformatf("vec%0d any", i), sif.spike_any, vt[i].any);
            check($sformatf("vec%0d cnt", i), sif.spike_cnt, vt[i].cnt);
        end

        // Refractory period 3 on channel 1 with a strobe every cycle.
        sif.cnt_clr    = 1'b0;
        sif.theta      = 4'd8;
        sif.u          = 16'h00F0;
        sif.ref_period = 3'd3;
        sif.en         = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("refA%0d spike", c), sif.spike, (c % 4 == 1) ? 4'b0010 : 4'b0000);
            check($sformatf("refA%0d refr", c), sif.refractory, (c % 4 != 0) ? 4'b0010 : 4'b0000);
        end

        // Strobe on every other cycle: refire gap doubles in clock cycles.
        for (int c = 1; c <= 16; c++) begin
            sif.en = (c % 2 == 1);
            tick();
            check($sformatf("refT%0d spike", c), sif.spike, (c == 1 || c == 9) ? 4'b0010 : 4'b0000);
            check($sformatf("refT%0d any", c), sif.spike_any, (c == 1 || c == 9));
            check($sformatf("refT%0d refr", c), sif.refractory, (((c - 1) % 8) < 6) ? 4'b0010 : 4'b0000);
        end

        // Channel 2: ref_period drops to 0 while two strobes remain in flight.
        sif.en         = 1'b1;
        sif.u          = 16'h0F00;
        sif.ref_period = 3'd3;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) sif.ref_period = 3'd0;
            tick();
            check($sformatf("refB%0d spike", c), sif.spike,
                  (c == 1 || c >= 5) ? 4'b0100 : 4'b0000);
            check($sformatf("refB%0d refr", c), sif.refractory, (c <= 3) ? 4'b0100 : 4'b0000);
        end

        // Counter saturation and clear with concurrent spikes.
        sif.en      = 1'b0;
        sif.cnt_clr = 1'b1;
        tick();
        check("sat clr0", sif.spike_cnt, 8'd0);
        sif.cnt_clr = 1'b0;
        sif.en      = 1'b1;
        sif.u       = 16'hFFFF;
        repeat (63) tick();
        check("sat 252", sif.spike_cnt, 8'd252);
        sif.u = 16'h000F;
        tick();
        check("sat 253", sif.spike_cnt, 8'd253);
        sif.u = 16'hFFFF;
        tick();
        check("sat 255a", sif.spike_cnt, 8'd255);
        tick();
        check("sat 255b", sif.spike_cnt, 8'd255);
        check("sat spike", sif.spike, 4'hF);
        sif.cnt_clr = 1'b1;
        tick();
        check("clr spike", sif.spike, 4'hF);
        check("clr cnt", sif.spike_cnt, 8'd0);
        sif.cnt_clr = 1'b0;

        // Asynchronous reset while every channel is refractory.
        sif.ref_period = 3'd5;
        tick();
        check("arst pre spike", sif.spike, 4'hF);
        check("arst pre cnt", sif.spike_cnt, 8'd4);
        tick();
        check("arst pre refr", sif.refractory, 4'hF);
        check("arst pre spike0", sif.spike, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst refr", sif.refractory, 4'h0);
        check("arst cnt", sif.spike_cnt, 8'd0);
        check("arst spike", sif.spike, 4'h0);
        check("arst any", sif.spike_any, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("post spike", sif.spike, 4'hF);
        check("post any", sif.spike_any, 1'b1);
        check("post refr", sif.refractory, 4'hF);
        check("post cnt", sif.spike_cnt, 8'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spike_gen_refractory.md
Name: spike_gen_refractory

Overview:
Multi-channel threshold spike generator with a per-channel refractory period and a saturating spike counter. Each channel compares its membrane potential u against a shared threshold theta on every enable strobe. It emits a one-cycle registered spike, then ignores that channel for a programmable number of strobes. It sits between the neuron membrane integrators and the spike routing/readout logic.

Parameters:
N_CH, 4, number of independent channels
U_W, 4, membrane potential and threshold width in bits (unsigned)
REF_W, 3, refractory counter width in bits
CNT_W, 8, total-spike counter width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  update strobe; channel evaluation happens only on cycles with en=1
u  input  N_CH*U_W  packed membrane potentials; channel i = u[i*U_W +: U_W]
theta  input  U_W  shared firing threshold, unsigned
ref_period  input  REF_W  refractory length in en-strobes, sampled at spike time
cnt_clr  input  1  synchronous clear of spike_cnt
spike  output  N_CH  registered spike pulses, one bit per channel
refractory  output  N_CH  1 while channel refractory counter is nonzero
spike_any  output  1  registered OR of the spike bits computed in the same cycle
spike_cnt  output  CNT_W  saturating count of all spikes emitted since reset or clear

Behaviour:
- Reset (rst_n=0, asynchronous): spike=0, refractory=0, spike_any=0, spike_cnt=0, all ref_cnt[i]=0. On deassertion, the first active edge behaves normally.
- Compare per channel: ge[i] = carry-out of the (U_W+1)-bit sum u_i + (~theta) + 1. This equals unsigned u_i >= theta. theta=0 means ge is always 1.
- Per channel, two states: READY (ref_cnt=0) and REFRACT (ref_cnt!=0). refractory[i] = (ref_cnt[i]!=0), driven from the register.
- On a cycle with en=1:
  - READY and ge=1: spike[i]<=1 on the next edge (latency 1 cycle), and ref_cnt[i]<=ref_period.
  - READY and ge=0: spike[i]<=0, and the channel stays READY.
  - REFRACT: spike[i]<=0 regardless of u, and ref_cnt[i]<=ref_cnt[i]-1.
- On a cycle with en=0: spike<=0 for all channels, ref_cnt holds, spike_cnt holds unless cleared. Every spike is therefore a single-cycle pulse.
- ref_period=0: no refractory. The channel can fire on every consecutive en strobe while ge=1.
- ref_period=R>0: after a spike, the next R en-strobes are suppressed. Earliest refire is on strobe R+1 after the firing strobe.
- A change to ref_period while a channel is refractory does not affect the count in flight.
- Channels are fully independent. Any subset may spike on the same edge.
- spike_any is registered in the same edge as spike and equals OR of the new spike bits.
- spike_cnt update, evaluated each edge:
  - cnt_clr=1: spike_cnt<=0. Spikes produced on that same edge are discarded from the count.
  - Otherwise: spike_cnt<=min(spike_cnt + popcount(new spike bits), 2^CNT_W-1). Saturates and never wraps.
- Reset mid-refractory clears all counters. All channels return to READY immediately.

Test Plan:
- Reset, then en=1, theta=8, u=all 8, ref_period=0 -> next cycle spike=4'b1111, spike_any=1, spike_cnt=4. Held for 3 strobes -> spike high each strobe cycle, spike_cnt=12.
- theta=8, channel0 u=7, others u=15 -> spike=4'b1110. Set channel0 u=8 -> spike[0]=1 on the next strobe (boundary equality fires).
- ref_period=3, channel1 u=15, en every cycle -> spike[1] on strobes 1,5,9. refractory[1]=1 for the 3 cycles after each spike. Then en toggled every other cycle -> spike gaps double, and spike stays 0 on en=0 cycles.
- Channel2 in REFRACT with ref_cnt=2; ref_period changed 3->0 -> still suppressed for 2 strobes, then fires every strobe.
- CNT_W=8, spike_cnt=253, 4 simultaneous spikes -> spike_cnt=255 and stays at 255. cnt_clr=1 asserted with concurrent spikes -> spike_cnt=0.
- rst_n pulsed low asynchronously mid-cycle while channels are refractory -> outputs go 0 immediately without a clock edge. First strobe after release with u>=theta fires all channels.
